matrix_input_parser: RTL

- Sits directly upstream of the central state machine.
- Converts the UART receive byte stream (ASCII decimal tokens separated by spaces or commas, lines ended by CR/LF) into one-cycle token strobes: decoder_valid, decoder_data, newline_rx, dim_invalid, data_invalid and need_fill.
- Captures rows/cols during the dimension phase and counts elements during the data phase, so need_fill is exact at end of line.

---
 rtl/matrix_input_parser_if.sv | 33 +++
 rtl/matrix_input_parser.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/matrix_input_parser_if.sv
// matrix_input_parser_if: UART byte stream in, token strobes out.
// master drives bytes and phase control; slave is the parser.
interface matrix_input_parser_if #(
  parameter int CNT_W = 5
);
  logic             enable;
  logic             dim_phase;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             decoder_valid;
  logic [31:0]      decoder_data;
  logic             newline_rx;
  logic             dim_invalid;
  logic             data_invalid;
  logic             need_fill;
  logic [2:0]       rows;
  logic [2:0]       cols;
  logic [CNT_W-1:0] elem_count;

  modport master (
    output enable, dim_phase, rx_data, rx_valid,
    input  decoder_valid, decoder_data, newline_rx,
    input  dim_invalid, data_invalid, need_fill,
    input  rows, cols, elem_count
  );

  modport slave (
    input  enable, dim_phase, rx_data, rx_valid,
    output decoder_valid, decoder_data, newline_rx,
    output dim_invalid, data_invalid, need_fill,
    output rows, cols, elem_count
  );
endinterface

// File: rtl/matrix_input_parser.sv
// matrix_input_parser: ASCII decimal tokens -> one-cycle token strobes.
// Ports: clk, rst (sync, active-low), bus (slave: bytes in, strobes,
// rows/cols and element count out).
module matrix_input_parser #(
  parameter int MAX_DIM  = 5,
  parameter int DATA_MIN = 0,
  parameter int DATA_MAX = 9,
  parameter int CNT_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  matrix_input_parser_if.slave bus
);
  typedef enum logic [1:0] {P_IDLE, P_SIGN, P_NUM} pstate_t;

  pstate_t            state, state_nx;
  logic [31:0]        acc, acc_nx;
  logic               neg, neg_nx;
  logic               mal, mal_nx;
  logic               cr, cr_nx;
  logic               idx, idx_nx;
  logic [2:0]         rows_nx, cols_nx;
  logic [CNT_W-1:0]   cnt_base, cnt_nx;
  logic               emit, eol, fill;
  logic               tok_mal, dim_bad, dat_bad;
  logic signed [31:0] tok_val;
  logic [5:0]         prod;
  logic [35:0]        acc_x10;
  logic [7:0]         b;
  logic               is_dig, is_min, is_sep, is_trm;

  assign b      = bus.rx_data;
  assign is_dig = (b >= 8'h30) && (b <= 8'h39);
  assign is_min = (b == 8'h2D);
  assign is_sep = (b == 8'h20) || (b == 8'h2C);
  assign is_trm = (b == 8'h0D) || (b == 8'h0A);

  assign acc_x10 = {4'd0, acc} * 36'd10 + {32'd0, b[3:0]};
  assign prod    = {3'd0, bus.rows} * {3'd0, bus.cols};

  // count is cleared the cycle after a newline
  assign cnt_base = bus.newline_rx ? '0 : bus.elem_count;

  // a lone minus sign emits as malformed
  assign tok_mal = mal | (state == P_SIGN);
  assign tok_val = tok_mal ? '0 :
                   neg     ? -$signed(acc) : $signed(acc);

  assign dim_bad = tok_mal | (tok_val < 1) | (tok_val > MAX_DIM);
  assign dat_bad = tok_mal | (tok_val < DATA_MIN) |
                   (tok_val > DATA_MAX) |
                   (32'(cnt_base) >= 32'(prod));

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    neg_nx   = neg;
    mal_nx   = mal;
    cr_nx    = cr;
    emit     = 1'b0;
    eol      = 1'b0;
    if (!bus.enable) begin
      state_nx = P_IDLE;
      acc_nx   = '0;
      neg_nx   = 1'b0;
      mal_nx   = 1'b0;
    end else if (bus.rx_valid) begin
      cr_nx = (b == 8'h0D);
      // LF right after CR is swallowed
      if (!(cr && (b == 8'h0A))) begin
        unique case (state)
          P_IDLE: unique case (1'b1)
            is_dig: begin
              state_nx = P_NUM;
              acc_nx   = {28'd0, b[3:0]};
            end
            is_min: state_nx = P_SIGN;
            is_sep: state_nx = P_IDLE;
            is_trm: eol = 1'b1;
            default: begin
              state_nx = P_NUM;
              mal_nx   = 1'b1;
            end
          endcase
          P_SIGN: unique case (1'b1)
            is_dig: begin
              state_nx = P_NUM;
              neg_nx   = 1'b1;
              acc_nx   = {28'd0, b[3:0]};
            end
            is_sep, is_trm: begin
              emit = 1'b1;
              eol  = is_trm;
            end
            default: begin
              state_nx = P_NUM;
              mal_nx   = 1'b1;
            end
          endcase
          default: unique case (1'b1)
            is_dig: begin
              if (!mal) begin
                if (acc_x10 > 36'h0_7FFF_FFFF)
                  mal_nx = 1'b1;
                else
                  acc_nx = acc_x10[31:0];
              end
            end
            is_sep, is_trm: begin
              emit = 1'b1;
              eol  = is_trm;
            end
            default: mal_nx = 1'b1;
          endcase
        endcase
        if (emit) begin
          state_nx = P_IDLE;
          acc_nx   = '0;
          neg_nx   = 1'b0;
          mal_nx   = 1'b0;
        end
      end
    end
  end

  always_comb begin
    rows_nx = bus.rows;
    cols_nx = bus.cols;
    idx_nx  = idx;
    cnt_nx  = cnt_base;
    if (!bus.enable) begin
      idx_nx = 1'b0;
      cnt_nx = '0;
    end else if (emit && bus.dim_phase) begin
      if (dim_bad) begin
        idx_nx = 1'b0;
      end else if (!idx) begin
        rows_nx = tok_val[2:0];
        idx_nx  = 1'b1;
      end else begin
        cols_nx = tok_val[2:0];
        idx_nx  = 1'b0;
      end
    end else if (emit && !dat_bad) begin
      cnt_nx = cnt_base + CNT_W'(1);
    end
  end

  assign fill = eol & ~bus.dim_phase &
                (32'(cnt_nx) < 32'(prod));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= P_IDLE;
      acc               <= '0;
      neg               <= 1'b0;
      mal               <= 1'b0;
      cr                <= 1'b0;
      idx               <= 1'b0;
      bus.decoder_valid <= 1'b0;
      bus.decoder_data  <= '0;
      bus.newline_rx    <= 1'b0;
      bus.dim_invalid   <= 1'b0;
      bus.data_invalid  <= 1'b0;
      bus.need_fill     <= 1'b0;
      bus.rows          <= '0;
      bus.cols          <= '0;
      bus.elem_count    <= '0;
    end else begin
      state             <= state_nx;
      acc               <= acc_nx;
      neg               <= neg_nx;
      mal               <= mal_nx;
      cr                <= cr_nx;
      idx               <= idx_nx;
      bus.decoder_valid <= emit;
      if (emit)
        bus.decoder_data <= tok_val;
      bus.newline_rx    <= eol;
      bus.dim_invalid   <= emit & bus.dim_phase & dim_bad;
      bus.data_invalid  <= emit & ~bus.dim_phase & dat_bad;
      bus.need_fill     <= fill;
      bus.rows          <= rows_nx;
      bus.cols          <= cols_nx;
      bus.elem_count    <= cnt_nx;
    end
  end
endmodule
